convnn_input_loader: RTL and testbench
======================================

// Module: convnn_input_loader
// PURPOSE
//  Upstream stage of convnn: accepts the input image as a valid/ready pixel stream
//  (3 channels packed per word) and writes it into a ping-pong pair of feature banks.
//  Serves convnn's layer1 read ports (addra/addrb/rden) from the full bank and drives
//  convnn enable/reset, so frame N+1 loads while frame N is processed.
// PARAMETERS
//  DATA_WIDTH   16    bits per channel sample
//  NUM_CH       3     channels packed per word (word = DATA_WIDTH*NUM_CH = 48 bits)
//  ADDR_WIDTH   12    layer1 feature address width
//  FRAME_WORDS  1024  words per frame (must be <= 2**ADDR_WIDTH)
// PORTS
//  clock        in   1      single clock, all logic rising-edge
//  reset        in   1      asynchronous, active-low; all state cleared on assertion
//  s_valid      in   1      pixel word valid
//  s_ready      out  1      loader can accept word this cycle
//  s_data       in   48     {ch2,ch1,ch0} pixel word
//  s_last       in   1      marks final word of frame
//  net_addra    in   12     convnn layer1_in_feature_addra
//  net_addrb    in   12     convnn layer1_in_feature_addrb
//  net_rden_a   in   1      convnn read enable A (wren_a/b from convnn are not connected)
//  net_rden_b   in   1      convnn read enable B
//  net_q_a_all  out  48     read data port A, 1-cycle latency
//  net_q_b_all  out  48     read data port B, 1-cycle latency
//  net_enable   out  1      drives convnn enable
//  net_reset    out  1      drives convnn reset (convnn polarity: active-high)
//  net_done     in   1      1-cycle pulse: convnn finished current frame
//  frame_err    out  1      sticky: s_last/word-count mismatch seen
// BEHAVIOUR
//  Reset values: s_ready=0, net_q_*=0, net_enable=0, net_reset=1, frame_err=0,
//   both banks EMPTY, wr_bank=0, rd_bank=0, wr_ptr=0. RAM contents not cleared.
//  Bank state per bank: EMPTY -> FILLING -> FULL -> IN_USE -> EMPTY.
//  Write FSM W_IDLE/W_FILL/W_WAIT: W_IDLE->W_FILL when bank[wr_bank] EMPTY.
//   s_ready=1 only in W_FILL. Transfer = s_valid&s_ready: write bank[wr_bank][wr_ptr],
//   wr_ptr++. Frame closes on wr_ptr==FRAME_WORDS-1 or s_last, whichever first:
//   bank->FULL, wr_ptr->0, wr_bank toggles, FSM->W_WAIT if new bank not EMPTY else W_FILL.
//   Close with (s_last XOR wr_ptr==FRAME_WORDS-1) sets frame_err; short frame is still
//   marked FULL (unwritten words hold stale data).
//  Read FSM R_IDLE/R_START/R_RUN: R_IDLE (net_reset=1, net_enable=0) -> R_START when
//   bank[rd_bank] FULL; R_START: bank->IN_USE, net_reset=0, net_enable=0, one cycle;
//   R_RUN: net_enable=1 until net_done; on net_done bank->EMPTY, rd_bank toggles,
//   ->R_IDLE (enable low, reset high for >=1 cycle between frames).
//  Reads: rden_x=1 -> q_x <= bank[rd_bank][addr_x] next cycle; rden_x=0 holds q_x.
//   addr_x >= FRAME_WORDS returns 0. Reads outside R_RUN return 0.
//  Simultaneous net_done and frame close on the other bank: both take effect same cycle;
//   the freed bank is visible to the write FSM next cycle.
//  net_done outside R_RUN is ignored. Reset mid-frame discards partial and full frames.
// CONFIGURATION
//  LOADER_STATS_EN defined: adds outputs frames_loaded[15:0] (incr on every frame close,
//   wraps) and frames_run[15:0] (incr on every accepted net_done). Undefined: ports and
//   counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package/header (convnn.vh): DATA_WIDTH, NUM_CH, layer1 ADDR_WIDTH, bank-state
//   and FSM state encodings.
//  Sub-module loader_bank_ram (x2): dual-port, registered output; port A = write mux /
//   read A, port B = read B. Banks never written and read in the same cycle.
// TESTING
//  Stream 1024 words, s_last on word 1023 -> bank0 FULL, net_enable=1 2 cycles later,
//   read addr 5 returns word 5 one cycle after rden_a.
//  Back-to-back 3 frames, net_done withheld -> s_ready=0 after frame 2 closes; pulse
//   net_done -> s_ready=1 next cycle, frame 3 lands in bank0.
//  s_last on word 99 -> frame_err=1, bank FULL, net_enable asserts; addr 1024 reads 0.
//  net_done in same cycle as frame close -> rd_bank toggles, new frame starts without stall.
//  reset low mid-fill at word 500 -> all outputs at reset values, next frame writes bank0
//   from addr 0.
//  LOADER_STATS_EN: 4 frames loaded, 3 net_done -> frames_loaded=4, frames_run=3.

Source files
------------

// File: rtl/convnn_input_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : convnn_input_loader_pkg
//  Description : Shared widths and state encodings for the convnn input loader.
//  Revision    : 1.0  initial release
// ============================================================================
package convnn_input_loader_pkg;

    localparam int LDR_DATA_WIDTH  = 16;
    localparam int LDR_NUM_CH      = 3;
    localparam int LDR_ADDR_WIDTH  = 12;
    localparam int LDR_FRAME_WORDS = 1024;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_IN_USE  = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_WAIT = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_RUN   = 2'd2
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/convnn_input_loader_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : convnn_input_loader_bank_ram
//  Description : One feature bank; port A writes or reads, port B reads only.
//  Revision    : 1.0  initial release
// ============================================================================
module convnn_input_loader_bank_ram #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clock,
    input  logic             en_a,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] din_a,
    output logic [WIDTH-1:0] q_a,
    input  logic             en_b,
    input  logic [AW-1:0]    addr_b,
    output logic [WIDTH-1:0] q_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q_a_q;
    logic [WIDTH-1:0] q_b_q;

    // Writes leave q_a untouched so a held read result survives refills.
    always_ff @(posedge clock) begin
        if (en_a) begin
            if (we_a) mem[addr_a] <= din_a;
            else      q_a_q       <= mem[addr_a];
        end
        if (en_b) q_b_q <= mem[addr_b];
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;

endmodule
`default_nettype wire

// File: rtl/convnn_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : convnn_input_loader
//  Description : Ping-pong pixel loader feeding convnn layer1; frame N+1 loads
//                while frame N runs. Define LOADER_STATS_EN for frame counters.
//  Revision    : 1.0  initial release
// ============================================================================
module convnn_input_loader
    import convnn_input_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = LDR_DATA_WIDTH,
    parameter int NUM_CH      = LDR_NUM_CH,
    parameter int ADDR_WIDTH  = LDR_ADDR_WIDTH,
    parameter int FRAME_WORDS = LDR_FRAME_WORDS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH*NUM_CH-1:0] s_data,
    input  logic                         s_last,
    input  logic [ADDR_WIDTH-1:0]        net_addra,
    input  logic [ADDR_WIDTH-1:0]        net_addrb,
    input  logic                         net_rden_a,
    input  logic                         net_rden_b,
    output logic [DATA_WIDTH*NUM_CH-1:0] net_q_a_all,
    output logic [DATA_WIDTH*NUM_CH-1:0] net_q_b_all,
    output logic                         net_enable,
    output logic                         net_reset,
    input  logic                         net_done,
    output logic                         frame_err
`ifdef LOADER_STATS_EN
    ,
    output logic [15:0]                  frames_loaded,
    output logic [15:0]                  frames_run
`endif
);

    localparam int WORD_W = DATA_WIDTH * NUM_CH;
    localparam int RAM_AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [RAM_AW-1:0] LAST_PTR = RAM_AW'(FRAME_WORDS - 1);

    wr_state_e         wr_st_q, wr_st_d;
    rd_state_e         rd_st_q, rd_st_d;
    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [RAM_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic              s_ready_q, s_ready_d;
    logic              net_enable_q, net_enable_d;
    logic              net_reset_q, net_reset_d;
    logic              frame_err_q, frame_err_d;
    logic              sel_a_q, sel_a_d, ok_a_q, ok_a_d;
    logic              sel_b_q, sel_b_d, ok_b_q, ok_b_d;

    logic              xfer, close, done_acc, rd_ok_a, rd_ok_b;
    logic [WORD_W-1:0] q_a_bank [2];
    logic [WORD_W-1:0] q_b_bank [2];

    assign xfer     = s_valid & s_ready_q;
    assign close    = xfer & (s_last | (wr_ptr_q == LAST_PTR));
    assign done_acc = net_done & (rd_st_q == R_RUN);
    assign rd_ok_a  = (rd_st_q == R_RUN) & (int'(net_addra) < FRAME_WORDS);
    assign rd_ok_b  = (rd_st_q == R_RUN) & (int'(net_addrb) < FRAME_WORDS);

    always_comb begin
        wr_st_d     = wr_st_q;
        rd_st_d     = rd_st_q;
        bank_d      = bank_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_ptr_d    = wr_ptr_q;
        frame_err_d = frame_err_q;
        sel_a_d     = sel_a_q;
        ok_a_d      = ok_a_q;
        sel_b_d     = sel_b_q;
        ok_b_d      = ok_b_q;

        // Both FSMs edit bank states; they never target the same bank in one cycle.
        case (wr_st_q)
            W_IDLE, W_WAIT: begin
                if (bank_q[wr_bank_q] == BANK_EMPTY) begin
                    wr_st_d            = W_FILL;
                    bank_d[wr_bank_q]  = BANK_FILLING;
                end
            end
            W_FILL: begin
                if (xfer) wr_ptr_d = wr_ptr_q + 1'b1;
                if (close) begin
                    bank_d[wr_bank_q] = BANK_FULL;
                    wr_ptr_d          = '0;
                    wr_bank_d         = ~wr_bank_q;
                    if (s_last != (wr_ptr_q == LAST_PTR)) frame_err_d = 1'b1;
                    if (bank_q[~wr_bank_q] == BANK_EMPTY) begin
                        wr_st_d            = W_FILL;
                        bank_d[~wr_bank_q] = BANK_FILLING;
                    end else begin
                        wr_st_d = W_WAIT;
                    end
                end
            end
            default: wr_st_d = W_IDLE;
        endcase

        case (rd_st_q)
            R_IDLE: begin
                if (bank_q[rd_bank_q] == BANK_FULL) begin
                    rd_st_d           = R_START;
                    bank_d[rd_bank_q] = BANK_IN_USE;
                end
            end
            R_START: rd_st_d = R_RUN;
            R_RUN: begin
                if (net_done) begin
                    bank_d[rd_bank_q] = BANK_EMPTY;
                    rd_bank_d         = ~rd_bank_q;
                    rd_st_d           = R_IDLE;
                end
            end
            default: rd_st_d = R_IDLE;
        endcase

        if (net_rden_a) begin
            sel_a_d = rd_bank_q;
            ok_a_d  = rd_ok_a;
        end
        if (net_rden_b) begin
            sel_b_d = rd_bank_q;
            ok_b_d  = rd_ok_b;
        end

        s_ready_d    = (wr_st_d == W_FILL);
        net_enable_d = (rd_st_d == R_RUN);
        net_reset_d  = (rd_st_d == R_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_st_q      <= W_IDLE;
            rd_st_q      <= R_IDLE;
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            s_ready_q    <= 1'b0;
            net_enable_q <= 1'b0;
            net_reset_q  <= 1'b1;
            frame_err_q  <= 1'b0;
            sel_a_q      <= 1'b0;
            ok_a_q       <= 1'b0;
            sel_b_q      <= 1'b0;
            ok_b_q       <= 1'b0;
        end else begin
            wr_st_q      <= wr_st_d;
            rd_st_q      <= rd_st_d;
            bank_q       <= bank_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            s_ready_q    <= s_ready_d;
            net_enable_q <= net_enable_d;
            net_reset_q  <= net_reset_d;
            frame_err_q  <= frame_err_d;
            sel_a_q      <= sel_a_d;
            ok_a_q       <= ok_a_d;
            sel_b_q      <= sel_b_d;
            ok_b_q       <= ok_b_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic wr_this, rd_a_this, rd_b_this;
        assign wr_this   = xfer & (wr_bank_q == 1'(b));
        assign rd_a_this = net_rden_a & rd_ok_a & (rd_bank_q == 1'(b));
        assign rd_b_this = net_rden_b & rd_ok_b & (rd_bank_q == 1'(b));

        convnn_input_loader_bank_ram #(
            .WIDTH (WORD_W),
            .DEPTH (FRAME_WORDS),
            .AW    (RAM_AW)
        ) u_ram (
            .clock  (clock),
            .en_a   (wr_this | rd_a_this),
            .we_a   (wr_this),
            .addr_a (wr_this ? wr_ptr_q : net_addra[RAM_AW-1:0]),
            .din_a  (s_data),
            .q_a    (q_a_bank[b]),
            .en_b   (rd_b_this),
            .addr_b (net_addrb[RAM_AW-1:0]),
            .q_b    (q_b_bank[b])
        );
    end

    assign s_ready     = s_ready_q;
    assign net_enable  = net_enable_q;
    assign net_reset   = net_reset_q;
    assign frame_err   = frame_err_q;
    assign net_q_a_all = ok_a_q ? q_a_bank[sel_a_q] : '0;
    assign net_q_b_all = ok_b_q ? q_b_bank[sel_b_q] : '0;

`ifdef LOADER_STATS_EN
    logic [15:0] frames_loaded_q, frames_loaded_d;
    logic [15:0] frames_run_q, frames_run_d;

    always_comb begin
        frames_loaded_d = frames_loaded_q + 16'(close);
        frames_run_d    = frames_run_q + 16'(done_acc);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frames_loaded_q <= '0;
            frames_run_q    <= '0;
        end else begin
            frames_loaded_q <= frames_loaded_d;
            frames_run_q    <= frames_run_d;
        end
    end

    assign frames_loaded = frames_loaded_q;
    assign frames_run    = frames_run_q;
`else
    logic unused_stats;
    assign unused_stats = done_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_convnn_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_convnn_input_loader
//  Description : Directed self-checking bench for the convnn input loader.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_convnn_input_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [47:0] s_data = '0;
    logic [11:0] net_addra = '0, net_addrb = '0;
    logic        net_rden_a = 1'b0, net_rden_b = 1'b0;
    logic [47:0] net_q_a_all, net_q_b_all;
    logic        net_enable, net_reset, frame_err;
    logic        net_done = 1'b0;
`ifdef LOADER_STATS_EN
    logic [15:0] frames_loaded, frames_run;
`endif

    convnn_input_loader dut (
        .clock       (clock),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .net_addra   (net_addra),
        .net_addrb   (net_addrb),
        .net_rden_a  (net_rden_a),
        .net_rden_b  (net_rden_b),
        .net_q_a_all (net_q_a_all),
        .net_q_b_all (net_q_b_all),
        .net_enable  (net_enable),
        .net_reset   (net_reset),
        .net_done    (net_done),
        .frame_err   (frame_err)
`ifdef LOADER_STATS_EN
        ,
        .frames_loaded (frames_loaded),
        .frames_run    (frames_run)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          sect;
        logic        port_b;
        logic [11:0] addr;
        logic [47:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[$];
    int      checks = 0;
    int      passed = 0;
    bit      stuck  = 1'b0;

    function automatic logic [47:0] word(input int f, input int i);
        logic [15:0] fi, ii;
        fi = 16'(f);
        ii = 16'(i);
        return {fi, ii, ii ^ 16'hA5A5};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        checks++;
        stuck = 1'b1;
        $display("FAIL %s: timed out waiting, got none expected event", name);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [47:0] d, input logic last);
        int budget = 3000;
        if (stuck) return;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!s_ready) timeout("s_ready_wait");
        else tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int f, input int n, input int last_idx);
        for (int i = 0; i < n; i++) send_word(word(f, i), i == last_idx);
    endtask

    task automatic wait_enable();
        int budget = 200;
        while (!net_enable && budget > 0) begin
            tick();
            budget--;
        end
        if (!net_enable) timeout("net_enable_wait");
    endtask

    task automatic pulse_done();
        wait_enable();
        net_done = 1'b1;
        tick();
        net_done = 1'b0;
    endtask

    task automatic do_read(input logic pb, input logic [11:0] a, output logic [47:0] q);
        if (pb) begin
            net_rden_b = 1'b1;
            net_addrb  = a;
        end else begin
            net_rden_a = 1'b1;
            net_addra  = a;
        end
        tick();
        net_rden_a = 1'b0;
        net_rden_b = 1'b0;
        q = pb ? net_q_b_all : net_q_a_all;
    endtask

    task automatic run_vecs(input int sect);
        logic [47:0] q;
        foreach (vecs[i]) begin
            if (vecs[i].sect == sect) begin
                do_read(vecs[i].port_b, vecs[i].addr, q);
                chk($sformatf("read_s%0d_%s_%0d", sect, vecs[i].port_b ? "b" : "a",
                              vecs[i].addr), {16'd0, q}, {16'd0, vecs[i].exp});
            end
        end
    endtask

    initial begin
        logic [47:0] q;

        vecs.push_back(rd_vec_t'{1, 1'b0, 12'd5,    word(0, 5)});
        vecs.push_back(rd_vec_t'{1, 1'b0, 12'd0,    word(0, 0)});
        vecs.push_back(rd_vec_t'{1, 1'b1, 12'd1023, word(0, 1023)});
        vecs.push_back(rd_vec_t'{1, 1'b1, 12'd77,   word(0, 77)});
        vecs.push_back(rd_vec_t'{1, 1'b0, 12'd1024, 48'd0});
        vecs.push_back(rd_vec_t'{2, 1'b0, 12'd5,    word(1, 5)});
        vecs.push_back(rd_vec_t'{3, 1'b0, 12'd5,    word(2, 5)});
        vecs.push_back(rd_vec_t'{4, 1'b1, 12'd5,    word(3, 5)});
        vecs.push_back(rd_vec_t'{4, 1'b0, 12'd1023, word(3, 1023)});
        vecs.push_back(rd_vec_t'{5, 1'b0, 12'd99,   word(4, 99)});
        vecs.push_back(rd_vec_t'{5, 1'b1, 12'd0,    word(4, 0)});
        vecs.push_back(rd_vec_t'{5, 1'b0, 12'd100,  word(2, 100)});
        vecs.push_back(rd_vec_t'{5, 1'b0, 12'd1024, 48'd0});
        vecs.push_back(rd_vec_t'{5, 1'b1, 12'd4095, 48'd0});
        vecs.push_back(rd_vec_t'{6, 1'b0, 12'd5,    48'd0});
        vecs.push_back(rd_vec_t'{7, 1'b0, 12'd0,    word(5, 0)});
        vecs.push_back(rd_vec_t'{7, 1'b0, 12'd1023, word(5, 1023)});
        vecs.push_back(rd_vec_t'{7, 1'b1, 12'd500,  word(5, 500)});

        // Reset state
        tick(2);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_q_a", net_q_a_all, 0);
        chk("rst_q_b", net_q_b_all, 0);
        chk("rst_enable", net_enable, 0);
        chk("rst_net_reset", net_reset, 1);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b1;
        tick();
        chk("s_ready_after_rst", s_ready, 1);

        // Full frame into bank0, convnn starts two cycles after close
        send_frame(0, 1024, 1023);
        chk("f0_enable_at_close", net_enable, 0);
        chk("f0_reset_at_close", net_reset, 1);
        chk("f0_s_ready_bank1", s_ready, 1);
        tick();
        chk("f0_start_reset", net_reset, 0);
        chk("f0_start_enable", net_enable, 0);
        tick();
        chk("f0_run_enable", net_enable, 1);
        chk("f0_frame_err", frame_err, 0);
        run_vecs(1);

        // Second frame fills bank1, then loader must stall
        send_frame(1, 1024, 1023);
        chk("f1_stall", s_ready, 0);
        tick(3);
        chk("f1_still_stall", s_ready, 0);
        net_done = 1'b1;
        tick();
        net_done = 1'b0;
        chk("done_s_ready_same", s_ready, 0);
        chk("done_enable_low", net_enable, 0);
        chk("done_reset_high", net_reset, 1);
        tick();
        chk("done_s_ready_next", s_ready, 1);
        chk("f1_start_reset", net_reset, 0);
        tick();
        chk("f1_run_enable", net_enable, 1);
        run_vecs(2);

        // Third frame lands in bank0
        send_frame(2, 1024, 1023);
        chk("f2_stall", s_ready, 0);
        pulse_done();
        tick(2);
        chk("f2_run_enable", net_enable, 1);
        run_vecs(3);

        // Frame close coincident with net_done on the other bank
        send_frame(3, 1023, -1);
        chk("f3_ready_before_close", s_ready, 1);
        s_valid  = 1'b1;
        s_data   = word(3, 1023);
        s_last   = 1'b1;
        net_done = 1'b1;
        tick();
        s_valid  = 1'b0;
        s_last   = 1'b0;
        net_done = 1'b0;
        chk("f3_close_reset", net_reset, 1);
        chk("f3_close_enable", net_enable, 0);
        chk("f3_close_s_ready", s_ready, 0);
        tick();
        chk("f3_start_reset", net_reset, 0);
        chk("f3_s_ready_back", s_ready, 1);
        tick();
        chk("f3_run_enable", net_enable, 1);
        chk("f3_frame_err", frame_err, 0);
        run_vecs(4);

        // Short frame: s_last on word 99
        send_frame(4, 100, 99);
        chk("f4_frame_err", frame_err, 1);
        chk("f4_stall", s_ready, 0);
        pulse_done();
        tick(2);
        chk("f4_run_enable", net_enable, 1);
        run_vecs(5);
        do_read(1'b0, 12'd7, q);
        chk("hold_first", {16'd0, q}, {16'd0, word(4, 7)});
        net_addra = 12'd8;
        tick();
        chk("hold_kept", {16'd0, net_q_a_all}, {16'd0, word(4, 7)});
        chk("f4_err_sticky", frame_err, 1);

        // Reader idle: reads return zero
        pulse_done();
        chk("idle_reset_high", net_reset, 1);
        run_vecs(6);

        // Reset in the middle of a fill
        send_frame(9, 500, -1);
        reset = 1'b0;
        #1;
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_q_a", net_q_a_all, 0);
        chk("mid_rst_q_b", net_q_b_all, 0);
        chk("mid_rst_enable", net_enable, 0);
        chk("mid_rst_net_reset", net_reset, 1);
        chk("mid_rst_frame_err", frame_err, 0);
`ifdef LOADER_STATS_EN
        chk("mid_rst_loaded", frames_loaded, 0);
        chk("mid_rst_run", frames_run, 0);
`endif
        tick(2);
        reset = 1'b1;
        tick();
        chk("post_rst_s_ready", s_ready, 1);
        send_frame(5, 1024, 1023);
        wait_enable();
        run_vecs(7);

`ifdef LOADER_STATS_EN
        send_frame(6, 10, 9);
        pulse_done();
        send_frame(7, 10, 9);
        pulse_done();
        send_frame(8, 10, 9);
        pulse_done();
        chk("stats_loaded", frames_loaded, 4);
        chk("stats_run", frames_run, 3);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
